// File: rtl/bus_arbiter_n.sv
// N-port bus arbiter: fixed-priority or round-robin grant, one dead TURN cycle
// between owners, optional MAX_HOLD revocation with per-port re-request masking.

module bus_arbiter_n_port #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  i_sel,
  input  logic [BUS_WIDTH-1:0]  i_bus,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic [BUS_WIDTH-1:0]  o_bus,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);
  assign o_bus  = i_sel ? i_bus  : '0;
  assign o_ctrl = i_sel ? i_ctrl : '0;
endmodule

module bus_arbiter_n #(
  parameter int N_PORTS    = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int RR_MODE    = 0,
  parameter int MAX_HOLD   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             req,
  input  logic [N_PORTS*BUS_WIDTH-1:0]   bus_in,
  input  logic [N_PORTS*CTRL_WIDTH-1:0]  ctrl_in,
  output logic [N_PORTS-1:0]             ack,
  output logic [BUS_WIDTH-1:0]           bus_out,
  output logic [CTRL_WIDTH-1:0]          ctrl_out,
  output logic [$clog2(N_PORTS)-1:0]     grant_idx,
  output logic                           busy,
  output logic                           timeout
);
  localparam int IW = $clog2(N_PORTS);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_PORT = IW'(N_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t            r_state;
  logic [N_PORTS-1:0] r_ack;
  logic [N_PORTS-1:0] r_mask;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_ptr;
  logic [HW-1:0]     r_hold;
  logic              r_timeout;

  logic [N_PORTS-1:0] w_elig;
  logic               w_any;
  logic [IW-1:0]      w_win;
  logic [N_PORTS-1:0][BUS_WIDTH-1:0]  w_bus_g;
  logic [N_PORTS-1:0][CTRL_WIDTH-1:0] w_ctrl_g;
  logic [BUS_WIDTH-1:0]  w_bus;
  logic [CTRL_WIDTH-1:0] w_ctrl;

  // a timed-out port stays masked until its req is seen low
  assign w_elig = req & ~r_mask;
  assign w_any  = |w_elig;

  always_comb begin
    int j;
    j     = 0;
    w_win = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N_PORTS; i++)
        if (w_elig[i]) w_win = IW'(i);
    end else begin
      // descending scan so the candidate nearest r_ptr is written last
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        j = int'(r_ptr) + k;
        if (j >= N_PORTS) j = j - N_PORTS;
        if (w_elig[IW'(j)]) w_win = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ack     <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_mask    <= r_mask & req;
      case (r_state)
        S_GRANT: begin
          if (!req[r_idx]) begin
            r_ack   <= '0;
            r_state <= S_TURN;
          end else if (MAX_HOLD > 0 && r_hold == HOLD_LAST) begin
            r_ack         <= '0;
            r_state       <= S_TURN;
            r_timeout     <= 1'b1;
            r_mask[r_idx] <= 1'b1;
          end else if (r_hold != HOLD_SAT) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_ack   <= N_PORTS'(1) << w_win;
            r_idx   <= w_win;
            r_hold  <= '0;
            r_ptr   <= (w_win == LAST_PORT) ? '0 : w_win + 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    bus_arbiter_n_port #(.BUS_WIDTH(BUS_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_port (
      .i_sel  (r_ack[g]),
      .i_bus  (bus_in[g*BUS_WIDTH +: BUS_WIDTH]),
      .i_ctrl (ctrl_in[g*CTRL_WIDTH +: CTRL_WIDTH]),
      .o_bus  (w_bus_g[g]),
      .o_ctrl (w_ctrl_g[g])
    );
  end

  // ack is one-hot-or-zero, so an OR of the gated slices is the mux
  always_comb begin
    w_bus  = '0;
    w_ctrl = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_bus  = w_bus  | w_bus_g[i];
      w_ctrl = w_ctrl | w_ctrl_g[i];
    end
  end

  assign ack       = r_ack;
  assign busy      = |r_ack;
  assign timeout   = r_timeout;
  assign grant_idx = r_idx;
  assign bus_out   = w_bus;
  assign ctrl_out  = w_ctrl;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Four arbiter configurations on shared data buses, checked each cycle against
// an ownership-level model, plus directed literal checks of key scenarios.

module tb_bus_arbiter_n;
  localparam int NI = 4;

  function automatic int rr_of(input int g);
    return (g == 1 || g == 2) ? 1 : 0;
  endfunction
  function automatic int mh_of(input int g);
    return (g == 2) ? 16 : ((g == 3) ? 3 : 0);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0][7:0]  req;
  logic [255:0]        bus_in;
  logic [63:0]         ctrl_in;
  logic [NI-1:0][7:0]  ack;
  logic [NI-1:0][31:0] bus_out;
  logic [NI-1:0][7:0]  ctrl_out;
  logic [NI-1:0][2:0]  gidx;
  logic [NI-1:0]       busy;
  logic [NI-1:0]       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_arbiter_n #(.N_PORTS(8), .BUS_WIDTH(32), .CTRL_WIDTH(8),
                    .RR_MODE(rr_of(g)), .MAX_HOLD(mh_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req[g]), .bus_in(bus_in), .ctrl_in(ctrl_in),
      .ack(ack[g]), .bus_out(bus_out[g]), .ctrl_out(ctrl_out[g]),
      .grant_idx(gidx[g]), .busy(busy[g]), .timeout(tmo[g])
    );
  end

  // model: current owner (-1 none), cycles owned, RR start, blocked ports
  int         own   [NI];
  int         owned [NI];
  int         ptr   [NI];
  logic [7:0] blk   [NI];
  logic       tpulse[NI];

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int n = 0; n < NI; n++) begin
      own[n] = -1; owned[n] = 0; ptr[n] = 0; blk[n] = '0; tpulse[n] = 1'b0;
    end
  endtask

  function automatic int pick(input int n, input logic [7:0] el);
    if (rr_of(n) == 0) begin
      for (int i = 7; i >= 0; i--) if (el[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) if (el[(ptr[n] + k) % 8]) return (ptr[n] + k) % 8;
    end
    return -1;
  endfunction

  task automatic step(input int n);
    logic [7:0] r;
    logic [7:0] el;
    int w;
    r  = req[n];
    el = r & ~blk[n];
    tpulse[n] = 1'b0;
    blk[n] = blk[n] & r;
    if (own[n] >= 0) begin
      owned[n]++;
      if (!r[own[n]]) own[n] = -1;
      else if (mh_of(n) > 0 && owned[n] == mh_of(n)) begin
        blk[n][own[n]] = 1'b1;
        own[n] = -1;
        tpulse[n] = 1'b1;
      end
    end else if (el != 8'd0) begin
      w = pick(n, el);
      own[n] = w; owned[n] = 0; ptr[n] = (w + 1) % 8;
    end
  endtask

  task automatic check_inst(input int n);
    logic [7:0]  ea;
    logic [31:0] eb;
    logic [7:0]  ec;
    ea = '0; eb = '0; ec = '0;
    if (own[n] >= 0) begin
      ea = 8'd1 << own[n];
      eb = bus_in[own[n]*32 +: 32];
      ec = ctrl_in[own[n]*8 +: 8];
    end
    chk("ack", n, 32'(ack[n]), 32'(ea));
    chk("busy", n, 32'(busy[n]), 32'(own[n] >= 0));
    chk("timeout", n, 32'(tmo[n]), 32'(tpulse[n]));
    chk("bus_out", n, bus_out[n], eb);
    chk("ctrl_out", n, 32'(ctrl_out[n]), 32'(ec));
    if (own[n] >= 0) chk("grant_idx", n, 32'(gidx[n]), 32'(own[n]));
    else if (!rst_n) chk("grant_idx_rst", n, 32'(gidx[n]), 32'd0);
    chk("ack_onehot0", n, 32'($onehot0(ack[n])), 32'd1);
    chk("busy_eq_or_ack", n, 32'(busy[n]), 32'(|ack[n]));
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else for (int n = 0; n < NI; n++) step(n);
      #1;
      for (int n = 0; n < NI; n++) check_inst(n);
    end
  endtask

  task automatic edge2();
    @(posedge clk); #2;
  endtask

  initial begin
    int cnt_ack;
    int cnt_to;
    req = '0;
    for (int i = 0; i < 8; i++) begin
      bus_in[i*32 +: 32] = 32'(32'h1111_1111 * (i + 1));
      ctrl_in[i*8 +: 8]  = 8'(8'h11 * (i + 1));
    end
    mdl_reset();
    fork monitor(); join_none

    repeat (3) edge2();
    chk("rst_ack", 0, 32'(ack[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_bus_out", 0, bus_out[0], 32'd0);
    chk("rst_ctrl_out", 0, 32'(ctrl_out[0]), 32'd0);
    chk("rst_grant_idx", 0, 32'(gidx[0]), 32'd0);
    chk("rst_timeout", 2, 32'(tmo[2]), 32'd0);

    // fixed priority pick and handoff through one dead cycle
    @(negedge clk); rst_n = 1'b1; req[0] = 8'b1001_0000;
    edge2();
    chk("fix_ack7", 0, 32'(ack[0]), 32'h80);
    chk("fix_bus7", 0, bus_out[0], 32'h8888_8888);
    chk("fix_idx7", 0, 32'(gidx[0]), 32'd7);
    @(negedge clk); req[0] = 8'b0001_0000;
    edge2();
    chk("handoff_turn", 0, 32'(ack[0]), 32'd0);
    edge2();
    chk("handoff_ack4", 0, 32'(ack[0]), 32'h10);
    chk("handoff_ctrl4", 0, 32'(ctrl_out[0]), 32'h55);
    @(negedge clk); req[0] = '0;
    repeat (3) @(posedge clk);

    // round robin, each owner keeps the bus for two cycles
    @(negedge clk); req[1] = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      edge2();
      chk("rr_grant", 1, 32'(ack[1]), 32'(8'd1 << (k % 8)));
      @(negedge clk);
      @(posedge clk);
      @(negedge clk); req[1] = 8'hFF & ~(8'd1 << (k % 8));
      edge2();
      chk("rr_turn", 1, 32'(ack[1]), 32'd0);
      @(negedge clk); req[1] = 8'hFF;
    end
    @(negedge clk); req[1] = '0;
    repeat (3) @(posedge clk);

    // MAX_HOLD=16 revocation and masking
    @(negedge clk); req[2] = 8'h08;
    cnt_ack = 0; cnt_to = 0;
    for (int c = 0; c < 40; c++) begin
      edge2();
      cnt_ack += int'(ack[2][3]);
      cnt_to  += int'(tmo[2]);
    end
    chk("to_hold_cycles", 2, 32'(cnt_ack), 32'd16);
    chk("to_pulses", 2, 32'(cnt_to), 32'd1);
    @(negedge clk); req[2] = '0;
    @(negedge clk); req[2] = 8'h08;
    edge2();
    chk("to_regrant", 2, 32'(ack[2]), 32'h08);
    @(negedge clk); req[2] = '0;
    repeat (3) @(posedge clk);

    // asynchronous reset pulse mid-grant
    @(negedge clk); req[0] = 8'h01;
    edge2();
    chk("pre_rst_ack", 0, 32'(ack[0]), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 0, 32'(ack[0]), 32'd0);
    chk("async_rst_bus", 0, bus_out[0], 32'd0);
    #2 rst_n = 1'b1;
    edge2();
    chk("post_rst_ack", 0, 32'(ack[0]), 32'h01);
    @(negedge clk); req[0] = '0;
    repeat (3) @(posedge clk);

    // randomized traffic on all instances
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int n = 0; n < NI; n++)
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 7) == 0) req[n][b] = ~req[n][b];
      bus_in  = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      ctrl_in = {$urandom(), $urandom()};
      if (c == 1200) begin
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    @(negedge clk); req = '0;
    repeat (4) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_n.md
BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 8, the number of requesting ports (2..16).
REQ-002 The block SHALL have parameter BUS_WIDTH, default 32, the data bus width per port.
REQ-003 The block SHALL have parameter CTRL_WIDTH, default 8, the control bus width per port.
REQ-004 The block SHALL have parameter RR_MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-005 The block SHALL have parameter MAX_HOLD, default 0, the maximum cycles a grant is held (0 = unlimited).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset. Ports are clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-007 req  input  N_PORTS  per-port bus request, level-held.
REQ-008 bus_in  input  N_PORTS*BUS_WIDTH  flattened port data; port i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-009 ctrl_in  input  N_PORTS*CTRL_WIDTH  flattened port control; port i occupies bits [i*CTRL_WIDTH +: CTRL_WIDTH].
REQ-010 ack  output  N_PORTS  one-hot-or-zero grant, registered.
REQ-011 bus_out  output  BUS_WIDTH  data of the granted port, zero when no grant.
REQ-012 ctrl_out  output  CTRL_WIDTH  control of the granted port, zero when no grant.
REQ-013 grant_idx  output  clog2(N_PORTS)  index of the current owner, valid only while busy=1.
REQ-014 busy  output  1  high while any ack bit is high.
REQ-015 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-016 The FSM SHALL have three states: IDLE, GRANT and TURN (one dead cycle between owners).
REQ-017 In IDLE with any eligible req high at edge t, the FSM SHALL go to GRANT and assert the winner's ack from cycle t+1.
REQ-018 Fixed mode SHALL select the highest-index eligible requester.
REQ-019 Round-robin mode SHALL search upward from (last owner + 1) mod N_PORTS, wrapping from index N_PORTS-1 to 0. The search pointer SHALL reset to index 0.
REQ-020 In GRANT, while the owner's req stays high, the grant SHALL hold regardless of other requests. There is no preemption except by MAX_HOLD.
REQ-021 When the owner's req is low at edge t, ack SHALL be low from cycle t+1 and the FSM SHALL enter TURN. The next grant SHALL appear no earlier than t+2.
REQ-022 TURN SHALL last exactly one cycle with all ack bits low. It SHALL then go to GRANT if an eligible req is high at that edge, otherwise to IDLE.
REQ-023 A hold counter SHALL clear on each new grant and increment each GRANT cycle. It SHALL saturate at MAX_HOLD and not wrap.
REQ-024 With MAX_HOLD>0, when the counter reaches MAX_HOLD cycles of ownership, ack SHALL drop, timeout SHALL pulse for 1 cycle and the FSM SHALL enter TURN.
REQ-025 A timed-out port SHALL be ineligible until its req has been sampled low at least once.
REQ-026 bus_out, ctrl_out and grant_idx SHALL be combinational muxes of the registered grant, so the owner's data passes through with zero latency.
REQ-027 A req that rises and falls while another port owns the bus SHALL be lost; no request latching is required.
REQ-028 A simultaneous owner req drop and MAX_HOLD expiry SHALL be treated as a normal release: no timeout pulse and no masking.
REQ-029 Any req of a non-owner during TURN SHALL be arbitrated at the TURN exit edge, including the previous owner if eligible.

Reset
REQ-030 While rst_n=0: ack=0, busy=0, timeout=0, bus_out=0, ctrl_out=0, grant_idx=0, FSM=IDLE, hold counter=0, RR pointer=0, timeout mask cleared.
REQ-031 Reset assertion mid-grant SHALL drop ack asynchronously within the same cycle.
REQ-032 The first grant after rst_n rises SHALL take at least one clk edge with req high.

Verification
REQ-033 Fixed mode, N_PORTS=8: req=8'b1001_0000 from IDLE -> ack=8'b1000_0000 next cycle, bus_out=bus_in[255:224], grant_idx=7.
REQ-034 Handoff: port 7 drops req while port 4 holds req -> one cycle with ack=0, then ack=8'b0001_0000 and ctrl_out=ctrl_in[39:32].
REQ-035 RR_MODE=1: req=8'hFF held, each owner releases after 2 cycles -> grant order 0,1,...,7,0 with one TURN cycle between owners.
REQ-036 MAX_HOLD=16: port 3 holds req for 40 cycles -> ack[3] high exactly 16 cycles, timeout pulses once, no regrant of port 3 until its req goes low and rises again.
REQ-037 rst_n pulsed low for 3 ns mid-grant -> ack=0 and bus_out=0 immediately; after release with req=8'h01 held -> ack=8'h01 one edge later.
REQ-038 The bench SHALL check continuously that ack is never multi-hot and that busy equals the OR of all ack bits.
